// File: rtl/hoplite_endpoint.sv
// Hoplite-RT tile endpoint: formats and rate-regulates client packets into a
// PE injection port, and captures every ejected packet into a client-side
// buffer while counting drops and misdeliveries. Internal FIFO helper lives
// in this file as well.

// Small synchronous FIFO with simultaneous push/pop at any occupancy.
// A push while full is only taken when a pop frees the head slot in the same
// cycle; the head reads as zero when empty so idle outputs are clean.
module hoplite_endpoint_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = empty_o ? '0 : mem_q[rp_q];

  // Storage array; contents are don't-care while their slot is unoccupied.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wp_q] <= wdata_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + 1'b1;
      if (pop_ok)  rp_q <= rp_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module hoplite_endpoint #(
  parameter int P_W       = 32,
  parameter int X_DIM     = 1,
  parameter int Y_DIM     = 1,
  parameter int MY_X      = 0,
  parameter int MY_Y      = 0,
  parameter int MAX_RATE  = 1,
  parameter int MAX_TOKEN = 1,
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4,
  localparam int XW    = (X_DIM == 1) ? 1 : $clog2(X_DIM),
  localparam int YW    = (Y_DIM == 1) ? 1 : $clog2(Y_DIM),
  localparam int D_W   = P_W - XW - YW,
  localparam int TOK_W = $clog2(MAX_TOKEN + 1)
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [D_W-1:0]   tx_data_i,
  input  logic [XW-1:0]    tx_dest_x_i,
  input  logic [YW-1:0]    tx_dest_y_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [P_W-1:0]   noc_pkt_o,
  output logic             noc_vld_o,
  input  logic             noc_rdy_i,
  input  logic [P_W-1:0]   noc_pkt_i,
  input  logic             noc_vld_i,
  output logic [D_W-1:0]   rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic [TOK_W-1:0] tokens_o,
  output logic [15:0]      drop_cnt_o,
  output logic [15:0]      misroute_cnt_o
);
  localparam int RW = (MAX_RATE > 1) ? $clog2(MAX_RATE) : 1;
  localparam logic [RW-1:0]    RATE_LAST = RW'(MAX_RATE - 1);
  localparam logic [TOK_W-1:0] TOK_MAX   = TOK_W'(MAX_TOKEN);
  localparam logic [XW-1:0]    MY_XV     = XW'(MY_X);
  localparam logic [YW-1:0]    MY_YV     = YW'(MY_Y);
  localparam logic [15:0]      CNT_SAT   = 16'hFFFF;

  // ---------------- TX path ----------------
  logic [XW-1:0]  tx_x;
  logic [YW-1:0]  tx_y;
  logic [P_W-1:0] tx_pkt;
  logic           tx_push, tx_empty, tx_full, fire;

  // Unused torus dimensions carry a constant-zero coordinate field.
  assign tx_x    = (X_DIM == 1) ? '0 : tx_dest_x_i;
  assign tx_y    = (Y_DIM == 1) ? '0 : tx_dest_y_i;
  assign tx_pkt  = {tx_x, tx_y, tx_data_i};

  assign tx_ready_o = !tx_full;
  assign tx_push    = tx_valid_i && tx_ready_o;

  logic [TOK_W-1:0] tok_q, tok_d, tok_after;
  logic [RW-1:0]    rate_q;
  logic             wrap;

  // Valid only needs a token and a head; both can only go away on a fire,
  // which keeps noc_vld_o/noc_pkt_o stable while the switch stalls us.
  assign noc_vld_o = !tx_empty && (tok_q != '0);
  assign fire      = noc_vld_o && noc_rdy_i;
  assign tokens_o  = tok_q;

  hoplite_endpoint_fifo #(.W(P_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i   (ap_clk),
    .rst_ni  (ap_rst_n),
    .push_i  (tx_push),
    .pop_i   (fire),
    .wdata_i (tx_pkt),
    .rdata_o (noc_pkt_o),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  assign wrap = (rate_q == RATE_LAST);

  // Bucket update: consume on fire first, then the wrap refills if there is
  // room, so fire+wrap at a full bucket ends back at MAX_TOKEN.
  always_comb begin
    tok_after = tok_q - TOK_W'(fire);
    tok_d     = tok_after;
    if (wrap && (tok_after < TOK_MAX)) tok_d = tok_after + 1'b1;
  end

  // Free-running replenish timer and token level.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rate_q <= '0;
      tok_q  <= TOK_MAX;
    end else begin
      rate_q <= wrap ? '0 : rate_q + 1'b1;
      tok_q  <= tok_d;
    end
  end

  // ---------------- RX path ----------------
  logic [XW-1:0]  rx_x;
  logic [YW-1:0]  rx_y;
  logic [D_W-1:0] rx_dat;
  logic           rx_hit, rx_miss, rx_pop, rx_push, rx_drop, rx_empty, rx_full;

  assign {rx_x, rx_y, rx_dat} = noc_pkt_i;

  assign rx_hit  = noc_vld_i && (rx_x == MY_XV) && (rx_y == MY_YV);
  assign rx_miss = noc_vld_i && !((rx_x == MY_XV) && (rx_y == MY_YV));
  assign rx_pop  = rx_valid_o && rx_ready_i;
  // The switch cannot be stalled: a full buffer only takes the packet if the
  // client frees a slot in the same cycle.
  assign rx_push = rx_hit && (!rx_full || rx_pop);
  assign rx_drop = rx_hit && rx_full && !rx_pop;

  assign rx_valid_o = !rx_empty;

  hoplite_endpoint_fifo #(.W(D_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (ap_clk),
    .rst_ni  (ap_rst_n),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .wdata_i (rx_dat),
    .rdata_o (rx_data_o),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  logic [15:0] drop_q, miss_q;

  // Saturating drop and misroute counters.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      drop_q <= '0;
      miss_q <= '0;
    end else begin
      if (rx_drop && (drop_q != CNT_SAT)) drop_q <= drop_q + 16'd1;
      if (rx_miss && (miss_q != CNT_SAT)) miss_q <= miss_q + 16'd1;
    end
  end

  assign drop_cnt_o     = drop_q;
  assign misroute_cnt_o = miss_q;
endmodule
